// File: rtl/ysyx_sq.sv
// ysyx_sq: post-commit store queue. Committed stores are buffered in FIFO order,
// drained one at a time to the data-memory write port, and forwarded to younger loads.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_WSTRB_SB
`define YSYX_WSTRB_SB 5'h10
`endif
`ifndef YSYX_WSTRB_SH
`define YSYX_WSTRB_SH 5'h11
`endif
`ifndef YSYX_WSTRB_SW
`define YSYX_WSTRB_SW 5'h12
`endif

module ysyx_sq #(
   parameter int SQ_SIZE = 4,
   parameter int XLEN    = `YSYX_XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            rou_lsu_valid,
   input  logic            rou_lsu_store,
   input  logic [4:0]      rou_lsu_alu,
   input  logic [XLEN-1:0] rou_lsu_sq_waddr,
   input  logic [XLEN-1:0] rou_lsu_sq_wdata,
   input  logic [XLEN-1:0] rou_lsu_pc,
   output logic            sq_ready,
   output logic            sq_empty,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   output logic [XLEN-1:0] mem_req_data,
   output logic [3:0]      mem_req_wstrb,
   input  logic            mem_resp_valid,
   input  logic            mem_resp_err,
   output logic            err_pulse,
   input  logic            ld_valid,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [4:0]      ld_alu,
   output logic            fwd_hit,
   output logic [XLEN-1:0] fwd_data,
   output logic            fwd_stall
);
   localparam int IDXW = $clog2(SQ_SIZE);
   localparam int CNTW = IDXW + 1;
   localparam int WAW  = XLEN - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [IDXW-1:0]     r_head;
   logic [IDXW-1:0]     r_tail;
   logic [CNTW-1:0]     r_count;
   logic [SQ_SIZE-1:0]  r_valid;
   logic [WAW-1:0]      r_waddr [SQ_SIZE];
   logic [XLEN-1:0]     r_data [SQ_SIZE];
   logic [3:0]          r_wstrb [SQ_SIZE];
   logic [XLEN-1:0]     r_pc_unused [SQ_SIZE];

   logic                w_enq;
   logic                w_pop;
   logic [3:0]          w_enq_wstrb;
   logic [XLEN-1:0]     w_enq_data;
   logic [3:0]          w_ld_mask;
   logic [IDXW-1:0]     w_scan_idx;
   logic [IDXW-1:0]     w_fwd_idx;
   logic                w_fwd_found;
   logic                w_overlap;
   logic                w_cover;

   // Unknown size codes are treated as a full word so forwarding errs toward a stall.
   function automatic logic [3:0] size_mask(input logic [4:0] alu, input logic [1:0] off);
      logic [3:0] m;
      case (alu)
         `YSYX_WSTRB_SB: m = 4'b0001 << off;
         `YSYX_WSTRB_SH: m = 4'b0011 << off;
         `YSYX_WSTRB_SW: m = 4'b1111;
         default:        m = 4'b1111;
      endcase
      return m;
   endfunction

   assign sq_ready    = (r_count != CNTW'(SQ_SIZE));
   assign sq_empty    = (r_count == CNTW'(0)) && (r_state == S_IDLE);
   assign w_enq       = rou_lsu_valid && rou_lsu_store && sq_ready;
   assign w_enq_wstrb = size_mask(rou_lsu_alu, rou_lsu_sq_waddr[1:0]);
   assign w_enq_data  = rou_lsu_sq_wdata << {rou_lsu_sq_waddr[1:0], 3'b000};

   // Drain state register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Drain next-state and write-port outputs.
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = {XLEN{1'b0}};
      mem_req_data  = {XLEN{1'b0}};
      mem_req_wstrb = 4'b0000;
      err_pulse     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != CNTW'(0)) w_state_nxt = S_ISSUE;
            else                     w_state_nxt = S_IDLE;
         end
         S_ISSUE: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_waddr[r_head], 2'b00};
            mem_req_data  = r_data[r_head];
            mem_req_wstrb = r_wstrb[r_head];
            if (mem_req_ready) w_state_nxt = S_WAIT;
            else               w_state_nxt = S_ISSUE;
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               w_pop       = 1'b1;
               err_pulse   = mem_resp_err;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Head/tail/count bookkeeping and per-entry valid bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head  <= IDXW'(0);
         r_tail  <= IDXW'(0);
         r_count <= CNTW'(0);
         r_valid <= {SQ_SIZE{1'b0}};
      end else begin
         if (w_enq) r_tail <= r_tail + IDXW'(1);
         if (w_pop) r_head <= r_head + IDXW'(1);
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
         for (int i = 0; i < SQ_SIZE; i++) begin
            if (w_pop && (r_head == IDXW'(i)))      r_valid[i] <= 1'b0;
            else if (w_enq && (r_tail == IDXW'(i))) r_valid[i] <= 1'b1;
         end
      end
   end

   // Entry payload, written at the tail on enqueue.
   always_ff @(posedge clock) begin
      if (w_enq) begin
         r_waddr[r_tail]     <= rou_lsu_sq_waddr[XLEN-1:2];
         r_data[r_tail]      <= w_enq_data;
         r_wstrb[r_tail]     <= w_enq_wstrb;
         r_pc_unused[r_tail] <= rou_lsu_pc;
      end
   end

   // Forwarding lookup: scan oldest to youngest so the last match is the youngest.
   always_comb begin
      w_ld_mask   = size_mask(ld_alu, ld_addr[1:0]);
      w_scan_idx  = r_head;
      w_fwd_idx   = r_head;
      w_fwd_found = 1'b0;
      w_overlap   = 1'b0;
      for (int k = 0; k < SQ_SIZE; k++) begin
         w_scan_idx = r_head + IDXW'(k);
         if (r_valid[w_scan_idx] && (r_waddr[w_scan_idx] == ld_addr[XLEN-1:2])) begin
            w_fwd_found = 1'b1;
            w_fwd_idx   = w_scan_idx;
            if ((r_wstrb[w_scan_idx] & w_ld_mask) != 4'b0000) w_overlap = 1'b1;
            else                                               w_overlap = w_overlap;
         end else begin
            w_fwd_found = w_fwd_found;
         end
      end
      w_cover   = w_fwd_found && ((w_ld_mask & ~r_wstrb[w_fwd_idx]) == 4'b0000);
      fwd_hit   = ld_valid && w_cover;
      fwd_stall = ld_valid && !w_cover && w_overlap;
      if (fwd_hit) fwd_data = r_data[w_fwd_idx];
      else         fwd_data = {XLEN{1'b0}};
   end
endmodule

// File: tb/tb_ysyx_sq.sv
// Self-checking bench for ysyx_sq: write requests are checked against a scoreboard
// queue filled at commit time; each scenario task checks its own flags inline.
`timescale 1ns/1ps
`ifndef YSYX_WSTRB_SB
`define YSYX_WSTRB_SB 5'h10
`endif
`ifndef YSYX_WSTRB_SH
`define YSYX_WSTRB_SH 5'h11
`endif
`ifndef YSYX_WSTRB_SW
`define YSYX_WSTRB_SW 5'h12
`endif

module tb_ysyx_sq;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rou_lsu_valid = 1'b0, rou_lsu_store = 1'b0;
   logic [4:0]  rou_lsu_alu = 5'd0;
   logic [31:0] rou_lsu_sq_waddr = 32'd0, rou_lsu_sq_wdata = 32'd0, rou_lsu_pc = 32'd0;
   logic        sq_ready, sq_empty, mem_req_valid, err_pulse, fwd_hit, fwd_stall;
   logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
   logic [31:0] mem_req_addr, mem_req_data, fwd_data;
   logic [3:0]  mem_req_wstrb;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [4:0]  ld_alu = 5'd0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wstrb;
   } req_t;

   req_t exp_q[$];
   int   checks = 0, failures = 0;
   int   writes_seen = 0, resp_delay = 2, cnt = 0;
   bit   ready_en = 1'b0, err_next = 1'b0, pending = 1'b0;

   ysyx_sq #(.SQ_SIZE(4), .XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .rou_lsu_valid(rou_lsu_valid), .rou_lsu_store(rou_lsu_store), .rou_lsu_alu(rou_lsu_alu),
      .rou_lsu_sq_waddr(rou_lsu_sq_waddr), .rou_lsu_sq_wdata(rou_lsu_sq_wdata), .rou_lsu_pc(rou_lsu_pc),
      .sq_ready(sq_ready), .sq_empty(sq_empty),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err), .err_pulse(err_pulse),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_alu(ld_alu),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
   );

   always #5 clock = ~clock;

   // Memory model: accepts requests when enabled, answers after resp_delay cycles, checks payloads.
   always @(negedge clock) begin
      req_t e;
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      if (reset) begin
         pending = 1'b0;
      end else begin
         if (pending) begin
            if (cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_err   = err_next;
               err_next       = 1'b0;
               pending        = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (mem_req_valid && ready_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL mem_req_unexpected addr=%h data=%h wstrb=%b", mem_req_addr, mem_req_data, mem_req_wstrb);
            end else begin
               e = exp_q.pop_front();
               if ({mem_req_addr, mem_req_data, mem_req_wstrb} !== {e.addr, e.data, e.wstrb}) begin
                  failures++;
                  $display("FAIL mem_req got addr=%h data=%h wstrb=%b want addr=%h data=%h wstrb=%b",
                           mem_req_addr, mem_req_data, mem_req_wstrb, e.addr, e.data, e.wstrb);
               end
            end
            pending = 1'b1;
            cnt     = resp_delay;
            writes_seen++;
         end
      end
      mem_req_ready = ready_en;
   end

   task automatic commit(input logic [4:0] alu, input logic [31:0] addr, input logic [31:0] data,
                         input bit accept, input logic [31:0] exp_data, input logic [3:0] exp_wstrb);
      req_t e;
      @(negedge clock);
      rou_lsu_valid    = 1'b1;
      rou_lsu_store    = 1'b1;
      rou_lsu_alu      = alu;
      rou_lsu_sq_waddr = addr;
      rou_lsu_sq_wdata = data;
      rou_lsu_pc       = 32'h8000_0100 + addr;
      if (accept) begin
         e.addr  = {addr[31:2], 2'b00};
         e.data  = exp_data;
         e.wstrb = exp_wstrb;
         exp_q.push_back(e);
      end
      @(negedge clock);
      rou_lsu_valid = 1'b0;
      rou_lsu_store = 1'b0;
   endtask

   task automatic wait_empty(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         #2;
         if (sq_empty && (exp_q.size() == 0)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({sq_ready, sq_empty, mem_req_valid, err_pulse, fwd_hit, fwd_stall} !== 6'b110000) begin
         failures++;
         $display("FAIL reset_flags got %b want 110000", {sq_ready, sq_empty, mem_req_valid, err_pulse, fwd_hit, fwd_stall});
      end
      checks++;
      if ({mem_req_addr, mem_req_data, mem_req_wstrb, fwd_data} !== 100'd0) begin
         failures++;
         $display("FAIL reset_data got addr=%h data=%h wstrb=%b fwd=%h want zeros", mem_req_addr, mem_req_data, mem_req_wstrb, fwd_data);
      end
   endtask

   task automatic test_store_word();
      bit ok;
      int base = writes_seen;
      ready_en = 1'b1;
      commit(`YSYX_WSTRB_SW, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      #1;
      checks++;
      if (sq_empty !== 1'b0) begin
         failures++;
         $display("FAIL sw_not_empty got %b want 0", sq_empty);
      end
      wait_empty(ok);
      checks++;
      if (!ok || writes_seen != base + 1) begin
         failures++;
         $display("FAIL sw_drain got empty=%0d writes=%0d want 1 writes=%0d", ok, writes_seen - base, 1);
      end
   endtask

   task automatic test_sub_word();
      bit ok;
      int base = writes_seen;
      ready_en = 1'b1;
      commit(`YSYX_WSTRB_SB, 32'h8000_0003, 32'h0000_00AB, 1'b1, 32'hAB00_0000, 4'b1000);
      commit(`YSYX_WSTRB_SH, 32'h8000_0002, 32'h0000_1234, 1'b1, 32'h1234_0000, 4'b1100);
      commit(`YSYX_WSTRB_SB, 32'h8000_0011, 32'h0000_00C3, 1'b1, 32'h0000_C300, 4'b0010);
      wait_empty(ok);
      checks++;
      if (!ok || writes_seen != base + 3) begin
         failures++;
         $display("FAIL subword_drain got empty=%0d writes=%0d want 1 writes=3", ok, writes_seen - base);
      end
   endtask

   task automatic test_full();
      bit ok, seen;
      int base = writes_seen;
      ready_en = 1'b0;
      for (int i = 0; i < 4; i++)
         commit(`YSYX_WSTRB_SW, 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 32'hA000_0000 + 32'(i), 4'b1111);
      #1;
      checks++;
      if (sq_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready got %b want 0", sq_ready);
      end
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin
         failures++;
         $display("FAIL full_hold got valid=%b addr=%h want valid=1 addr=00001000", mem_req_valid, mem_req_addr);
      end
      commit(`YSYX_WSTRB_SW, 32'h1010, 32'hBAD0_BAD0, 1'b0, 32'd0, 4'b0000);
      ready_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         #2;
         if (mem_resp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || sq_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_no_bypass got seen=%0d ready=%b want seen=1 ready=0", seen, sq_ready);
      end
      @(negedge clock);
      #2;
      checks++;
      if (sq_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_ready_after_pop got %b want 1", sq_ready);
      end
      wait_empty(ok);
      checks++;
      if (!ok || writes_seen != base + 4) begin
         failures++;
         $display("FAIL full_drain got empty=%0d writes=%0d want 1 writes=4", ok, writes_seen - base);
      end
   endtask

   task automatic test_forward();
      bit ok;
      req_t e;
      ready_en = 1'b0;
      commit(`YSYX_WSTRB_SW, 32'h100, 32'h1111_1111, 1'b1, 32'h1111_1111, 4'b1111);
      commit(`YSYX_WSTRB_SW, 32'h100, 32'h2222_2222, 1'b1, 32'h2222_2222, 4'b1111);
      ld_valid = 1'b1; ld_alu = `YSYX_WSTRB_SW; ld_addr = 32'h100;
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b10 || fwd_data !== 32'h2222_2222) begin
         failures++;
         $display("FAIL fwd_youngest got hit=%b stall=%b data=%h want 1 0 22222222", fwd_hit, fwd_stall, fwd_data);
      end
      ld_addr = 32'h104;
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b00) begin
         failures++;
         $display("FAIL fwd_miss got hit=%b stall=%b want 0 0", fwd_hit, fwd_stall);
      end
      commit(`YSYX_WSTRB_SB, 32'h200, 32'h0000_0055, 1'b1, 32'h0000_0055, 4'b0001);
      ld_addr = 32'h200; ld_alu = `YSYX_WSTRB_SW;
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b01) begin
         failures++;
         $display("FAIL fwd_partial got hit=%b stall=%b want 0 1", fwd_hit, fwd_stall);
      end
      ld_alu = `YSYX_WSTRB_SB;
      #1;
      checks++;
      if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data[7:0] !== 8'h55) begin
         failures++;
         $display("FAIL fwd_byte got hit=%b stall=%b data=%h want 1 0 xx55", fwd_hit, fwd_stall, fwd_data);
      end
      ld_addr = 32'h201;
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b00) begin
         failures++;
         $display("FAIL fwd_disjoint_byte got hit=%b stall=%b want 0 0", fwd_hit, fwd_stall);
      end
      ld_valid = 1'b0; ld_addr = 32'h100; ld_alu = `YSYX_WSTRB_SW;
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b00) begin
         failures++;
         $display("FAIL fwd_ld_invalid got hit=%b stall=%b want 0 0", fwd_hit, fwd_stall);
      end
      // Same-cycle enqueue must not be visible to the lookup.
      @(negedge clock);
      rou_lsu_valid = 1'b1; rou_lsu_store = 1'b1; rou_lsu_alu = `YSYX_WSTRB_SW;
      rou_lsu_sq_waddr = 32'h300; rou_lsu_sq_wdata = 32'h3333_3333; rou_lsu_pc = 32'h8000_0400;
      ld_valid = 1'b1; ld_addr = 32'h300;
      e.addr = 32'h300; e.data = 32'h3333_3333; e.wstrb = 4'b1111;
      exp_q.push_back(e);
      #1;
      checks++;
      if ({fwd_hit, fwd_stall} !== 2'b00) begin
         failures++;
         $display("FAIL fwd_same_cycle got hit=%b stall=%b want 0 0", fwd_hit, fwd_stall);
      end
      @(negedge clock);
      rou_lsu_valid = 1'b0; rou_lsu_store = 1'b0;
      #1;
      checks++;
      if (fwd_hit !== 1'b1 || fwd_data !== 32'h3333_3333) begin
         failures++;
         $display("FAIL fwd_next_cycle got hit=%b data=%h want 1 33333333", fwd_hit, fwd_data);
      end
      ld_valid = 1'b0;
      ready_en = 1'b1;
      wait_empty(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL fwd_drain got empty=0 want 1");
      end
   endtask

   task automatic test_error_and_reset();
      bit ok;
      int pulses = 0;
      int base = writes_seen;
      ready_en = 1'b1;
      err_next = 1'b1;
      commit(`YSYX_WSTRB_SW, 32'h400, 32'h4444_4444, 1'b1, 32'h4444_4444, 4'b1111);
      commit(`YSYX_WSTRB_SW, 32'h404, 32'h5555_5555, 1'b1, 32'h5555_5555, 4'b1111);
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         #2;
         if (err_pulse) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL err_pulse_width got %0d want 1", pulses);
      end
      checks++;
      if (writes_seen != base + 2 || sq_empty !== 1'b1) begin
         failures++;
         $display("FAIL err_pop got writes=%0d empty=%b want 2 1", writes_seen - base, sq_empty);
      end
      resp_delay = 6;
      base = writes_seen;
      commit(`YSYX_WSTRB_SW, 32'h500, 32'h6666_6666, 1'b1, 32'h6666_6666, 4'b1111);
      for (int i = 0; i < 20 && writes_seen == base; i++) begin
         @(negedge clock);
         #2;
      end
      @(negedge clock);
      reset = 1'b1;
      pending = 1'b0;
      exp_q.delete();
      @(negedge clock);
      #2;
      checks++;
      if (writes_seen != base + 1 ||
          {sq_ready, sq_empty, mem_req_valid, err_pulse, fwd_hit, fwd_stall} !== 6'b110000) begin
         failures++;
         $display("FAIL reset_in_wait got writes=%0d flags=%b want 1 110000", writes_seen - base,
                  {sq_ready, sq_empty, mem_req_valid, err_pulse, fwd_hit, fwd_stall});
      end
      reset = 1'b0;
      resp_delay = 2;
      repeat (6) @(negedge clock);
      #2;
      checks++;
      if (writes_seen != base + 1 || sq_empty !== 1'b1) begin
         failures++;
         $display("FAIL reset_clears_entries got writes=%0d empty=%b want 1 1", writes_seen - base, sq_empty);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_sub_word();
      test_full();
      test_forward();
      test_error_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ysyx_sq.md
Name: ysyx_sq

Overview:
- Post-commit store queue (SQ). It is the receiving end of the ROB commit interface `rou_lsu_if`, and it returns `sq_ready` to the ROB.
- Architecturally committed stores are buffered in FIFO order and drained one at a time to the data-memory write port.
- Younger loads get store-to-load forwarding. Overlapping partial matches are flagged as a stall.
- The block sits between the ROB commit stage and the LSU memory arbiter.

Parameters:
- SQ_SIZE, 4: queue depth in entries; must be a power of 2, at least 2.
- XLEN, `YSYX_XLEN (32): address and data width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rou_lsu_valid  in  1  ROB head commits this cycle
- rou_lsu_store  in  1  committing instruction is a store
- rou_lsu_alu  in  5  store size code: `YSYX_WSTRB_SB / _SH / _SW
- rou_lsu_sq_waddr  in  XLEN  store byte address
- rou_lsu_sq_wdata  in  XLEN  store data, right-aligned
- rou_lsu_pc  in  XLEN  store pc, kept for debug
- sq_ready  out  1  queue can accept a store this cycle
- sq_empty  out  1  no entries and no write outstanding
- mem_req_valid  out  1  write request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b0})
- mem_req_data  out  XLEN  lane-shifted data
- mem_req_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  write completion
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid
- err_pulse  out  1  one-cycle flag on an error completion
- ld_valid  in  1  load lookup
- ld_addr  in  XLEN  load byte address
- ld_alu  in  5  load size code (byte/half/word)
- fwd_hit  out  1  full forward available
- fwd_data  out  XLEN  forwarded word, lane-aligned
- fwd_stall  out  1  partial overlap; load must retry

Behaviour:
Reset:
- Head, tail and count are cleared to 0; all entry valid bits are cleared; FSM goes to IDLE.
- All outputs are 0 except `sq_ready`=1 and `sq_empty`=1.

Enqueue:
- Condition: `rou_lsu_valid && rou_lsu_store && sq_ready`.
- Entry written at tail: addr, `wstrb`, shifted data, pc.
  - `wstrb`: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
  - Data is shifted left by addr[1:0]*8.
- Tail increments and wraps modulo SQ_SIZE.

Ready and empty:
- `sq_ready` = (count != SQ_SIZE). It is combinational from registered state and never depends on this cycle's dequeue, so there is no full-bypass.
- `sq_empty` = (count == 0) && (state == IDLE).

Flush: `flush_pipe` is not an input. Committed stores are never discarded.

Drain FSM:
- IDLE: if count != 0, go to ISSUE.
- ISSUE:
  - `mem_req_valid`=1; addr/data/wstrb are driven from the head entry.
  - Signals hold stable until `mem_req_ready`, then go to WAIT.
- WAIT:
  - `mem_req_valid`=0.
  - On `mem_resp_valid`: pop head (head+1, count-1, clear valid) and go to IDLE.
  - If `mem_resp_err`=1, `err_pulse`=1 for that cycle and the entry is still popped.
- One bubble cycle between consecutive writes is accepted.

Count arithmetic:
- Count width is clog2(SQ_SIZE)+1.
- Simultaneous enqueue and pop in the same cycle leaves count unchanged.

Forwarding (combinational):
- Compare ld_addr[XLEN-1:2] against all valid entries, including the head while in ISSUE/WAIT.
- Select the youngest matching entry (nearest to tail).
- If that entry's `wstrb` covers every load byte:
  - `fwd_hit`=1.
  - `fwd_data` = entry data.
- Else, if any load byte overlaps any matching entry:
  - `fwd_stall`=1.
  - `fwd_hit`=0.
- With `ld_valid`=0, both flags are 0.
- Enqueue in the same cycle is not visible to the lookup.

Test Plan:
1. Reset, then commit SW addr=0x80000004 data=0xDEADBEEF -> next cycle `mem_req_valid`=1, addr=0x80000004, wstrb=4'b1111, data=0xDEADBEEF; resp after 3 cycles -> `sq_empty`=1.
2. SB addr=0x80000003 data=0xAB -> wstrb=4'b1000, data=0xAB000000.
3. Hold `mem_req_ready`=0 and commit 4 stores -> `sq_ready`=0 after the 4th; a 5th `rou_lsu_valid` is not enqueued. Release -> drained in order, `sq_ready`=1 the cycle after the first pop.
4. Queue SW 0x100=0x11111111 then SW 0x100=0x22222222; load LW 0x100 -> `fwd_hit`=1, `fwd_data`=0x22222222. Load LW 0x104 -> both flags 0.
5. Queue SB 0x200=0x55; load LW 0x200 -> `fwd_stall`=1. Load LB 0x200 -> `fwd_hit`=1, `fwd_data`[7:0]=0x55.
6. `mem_resp_err`=1 on the first completion -> `err_pulse` high exactly 1 cycle, entry popped, next entry issued. Assert reset while in WAIT -> all outputs at reset values next cycle.
